// File: rtl/fifo_pkg.sv
// Shared defaults, FSM state encoding and keep-mask helper for the FIFO read-side packer.
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int PACK_N_DEF     = 4;
   localparam int PACK_N_MAX     = 8;

   typedef enum logic [1:0] {
      ST_FILL       = 2'd0,
      ST_FLUSH_WAIT = 2'd1,
      ST_EMIT       = 2'd2
   } pack_state_e;

   function automatic logic [PACK_N_MAX-1:0] keep_from_cnt(input logic [3:0] cnt);
      logic [PACK_N_MAX-1:0] keep;
      keep = '0;
      for (int i = 0; i < PACK_N_MAX; i++) begin
         keep[i] = (4'(i) < cnt);
      end
      return keep;
   endfunction
endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port, flush control and packed output stream of the read-side packer.
// Output stream: a word transfers on a clock edge where out_valid & out_ready; once raised,
// out_valid and out_data/out_keep hold until that transfer, and out_ready may change freely.
interface fifo_rd_packer_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PACK_N     = PACK_N_DEF
);
   logic                         fifo_empty;
   logic [DATA_WIDTH-1:0]        fifo_rdata;
   logic                         fifo_rinc;
   logic                         flush;
   logic                         flush_done;
   logic                         out_valid;
   logic                         out_ready;
   logic [PACK_N*DATA_WIDTH-1:0] out_data;
   logic [PACK_N-1:0]            out_keep;

   modport master (
      input  fifo_empty, fifo_rdata, flush, out_ready,
      output fifo_rinc, flush_done, out_valid, out_data, out_keep
   );

   modport slave (
      output fifo_empty, fifo_rdata, flush, out_ready,
      input  fifo_rinc, flush_done, out_valid, out_data, out_keep
   );
endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Output word register: loads on strobe, holds data/keep until the downstream handshake.
module pack_out_reg #(
   parameter int WORD_W = 32,
   parameter int KEEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              ready_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] data_o,
   output logic [KEEP_W-1:0] keep_o,
   output logic              free_o
);
   logic              valid_q, valid_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic [KEEP_W-1:0] keep_q, keep_d;

   // Free when empty or when the held word leaves this cycle.
   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign keep_o  = keep_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         keep_d  = keep_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
      end
   end
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the FIFO read port and packs PACK_N of them little-endian per output word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PACK_N     = PACK_N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   fifo_rd_packer_if.master bus,
   output pack_state_e      dbg_state_o
);
   localparam int CNT_W  = $clog2(PACK_N + 1);
   localparam int WORD_W = PACK_N * DATA_WIDTH;

   pack_state_e                       state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d, cnt_cap;
   logic                              inflight_q;
   logic [PACK_N-1:0][DATA_WIDTH-1:0] acc_q, acc_d, acc_cap;
   logic [CNT_W:0]                    occupancy;
   logic                              room, rollover, rinc;
   logic                              out_valid, out_free, load;
   logic [PACK_N-1:0]                 ld_keep;

   assign occupancy = {1'b0, cnt_q} + (CNT_W+1)'(inflight_q);
   assign room      = occupancy < (CNT_W+1)'(PACK_N);
   // The landing byte completes a word into an idle output register, so lane 0 is free again
   // next cycle; popping now keeps back-to-back words free of read bubbles.
   assign rollover  = inflight_q && (cnt_q == CNT_W'(PACK_N - 1)) && !out_valid;
   assign rinc      = !rst && !bus.fifo_empty && (state_q == ST_FILL) && (room || rollover);

   assign bus.fifo_rinc  = rinc;
   assign bus.out_valid  = out_valid;
   assign bus.flush_done = (state_q == ST_EMIT);
   assign dbg_state_o    = state_q;

   always_comb begin
      acc_cap = acc_q;
      for (int i = 0; i < PACK_N; i++) begin
         if (inflight_q && (cnt_q == CNT_W'(i))) begin
            acc_cap[i] = bus.fifo_rdata;
         end
      end
      cnt_cap = cnt_q + CNT_W'(inflight_q);
      acc_d   = acc_cap;
      cnt_d   = cnt_cap;
      state_d = state_q;
      load    = 1'b0;
      ld_keep = '1;

      if ((cnt_cap == CNT_W'(PACK_N)) && out_free) begin
         load  = 1'b1;
         cnt_d = '0;
         acc_d = '0;
      end

      unique case (state_q)
         ST_FILL: begin
            if (bus.flush) state_d = ST_FLUSH_WAIT;
         end
         ST_FLUSH_WAIT: begin
            if (!inflight_q && out_free) begin
               if (cnt_q != '0) begin
                  load    = 1'b1;
                  ld_keep = PACK_N'(keep_from_cnt(4'(cnt_q)));
               end
               cnt_d   = '0;
               acc_d   = '0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            state_d = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FILL;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inflight_q <= rinc;
         acc_q      <= acc_d;
      end
   end

   pack_out_reg #(
      .WORD_W (WORD_W),
      .KEEP_W (PACK_N)
   ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .ready_i (bus.out_ready),
      .data_i  (acc_cap),
      .keep_i  (ld_keep),
      .valid_o (out_valid),
      .data_o  (bus.out_data),
      .keep_o  (bus.out_keep),
      .free_o  (out_free)
   );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO read-port model, word-level scoreboard, directed and random traffic.
module tb_fifo_rd_packer;
   import fifo_pkg::*;

   localparam int DW = 8;
   localparam int PN = 4;
   localparam int WW = DW * PN;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   pack_state_e dbg_state;
   always #5 clk = ~clk;

   fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_N(PN)) bus ();

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_N(PN)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // FIFO read port: one-cycle read latency, empty when drained or stalled
   logic [DW-1:0] fifo_mem [0:1023];
   int            push_cnt;
   int            pop_cnt;
   logic [DW-1:0] rdata_q;
   assign bus.fifo_empty = stall || (push_cnt == pop_cnt);
   assign bus.fifo_rdata = rdata_q;
   always @(posedge clk) begin
      if (rst) begin
         pop_cnt <= push_cnt;
      end else if (bus.fifo_rinc) begin
         rdata_q <= fifo_mem[pop_cnt % 1024];
         pop_cnt <= pop_cnt + 1;
      end
   end

   // scoreboard and statistics
   logic [WW-1:0] exp_q[$];
   logic [PN-1:0] exp_keep_q[$];
   logic [DW-1:0] pend_q[$];
   int            errors, checks;
   int            cycle, words_seen, fd_count, pops, run_len, max_run;
   int            last_pop_cycle, last_hs_cycle, prev_hs_cycle;
   logic [WW-1:0] last_data, hold_data;
   logic [PN-1:0] last_keep, hold_keep;
   logic          hold_prev;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      words_seen = 0;
      fd_count   = 0;
      pops       = 0;
      run_len    = 0;
      max_run    = 0;
   endtask

   // one clock: sample settled signals, then advance to the next negedge
   task automatic cyc();
      logic [WW-1:0] ed;
      logic [PN-1:0] ek;
      #1;
      cycle++;
      if (bus.fifo_empty) check("no_pop_when_empty", 64'(bus.fifo_rinc), 64'(0));
      if (hold_prev) begin
         check("hold_valid", 64'(bus.out_valid), 64'(1));
         check("hold_data", 64'(bus.out_data), 64'(hold_data));
         check("hold_keep", 64'(bus.out_keep), 64'(hold_keep));
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_keep = bus.out_keep;
      if (bus.out_valid && bus.out_ready) begin
         words_seen++;
         last_data     = bus.out_data;
         last_keep     = bus.out_keep;
         prev_hs_cycle = last_hs_cycle;
         last_hs_cycle = cycle;
         check("word_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            ed = exp_q.pop_front();
            ek = exp_keep_q.pop_front();
            check("word_data", 64'(bus.out_data), 64'(ed));
            check("word_keep", 64'(bus.out_keep), 64'(ek));
         end
      end
      if (bus.flush_done) fd_count++;
      if (bus.fifo_rinc) begin
         pops++;
         run_len++;
         last_pop_cycle = cycle;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // driver: every PN bytes pushed form one expected full word
   task automatic push_byte(input logic [DW-1:0] b);
      logic [WW-1:0] w;
      fifo_mem[push_cnt % 1024] = b;
      push_cnt++;
      pend_q.push_back(b);
      if (pend_q.size() == PN) begin
         w = '0;
         for (int i = 0; i < PN; i++) w[i*DW +: DW] = pend_q[i];
         exp_q.push_back(w);
         exp_keep_q.push_back('1);
         pend_q.delete();
      end
   endtask

   // leftover bytes become one partial word with low lanes kept
   task automatic do_flush();
      logic [WW-1:0] w;
      w = '0;
      if (pend_q.size() != 0) begin
         for (int i = 0; i < pend_q.size(); i++) w[i*DW +: DW] = pend_q[i];
         exp_q.push_back(w);
         exp_keep_q.push_back(PN'((1 << pend_q.size()) - 1));
         pend_q.delete();
      end
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
   endtask

   initial begin
      logic [WW-1:0] w;
      logic [DW-1:0] b;
      int            pushed;
      errors = 0; checks = 0; cycle = 0; push_cnt = 0;
      last_pop_cycle = 0; last_hs_cycle = 0; prev_hs_cycle = 0;
      hold_prev = 1'b0; hold_data = '0; hold_keep = '0;
      last_data = '0; last_keep = '0;
      rst = 1'b1; stall = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      clear_stats();

      // reset state
      @(negedge clk);
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'(0));
      check("rst_data", 64'(bus.out_data), 64'(0));
      check("rst_keep", 64'(bus.out_keep), 64'(0));
      check("rst_flush_done", 64'(bus.flush_done), 64'(0));
      check("rst_rinc", 64'(bus.fifo_rinc), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(ST_FILL));
      @(negedge clk);
      rst = 1'b0;
      run(2);

      // single word, latency from last pop
      clear_stats();
      bus.out_ready = 1'b1;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      run(12);
      check("t1_words", 64'(words_seen), 64'(1));
      check("t1_rinc_run", 64'(max_run), 64'(4));
      check("t1_latency", 64'(last_hs_cycle - last_pop_cycle), 64'(2));
      check("t1_data", 64'(last_data), 64'(32'h44332211));
      check("t1_keep", 64'(last_keep), 64'(4'hF));

      // back-to-back words
      clear_stats();
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      run(16);
      check("t2_words", 64'(words_seen), 64'(2));
      check("t2_rinc_run", 64'(max_run), 64'(8));
      check("t2_spacing", 64'(last_hs_cycle - prev_hs_cycle), 64'(4));
      check("t2_data", 64'(last_data), 64'(32'h08070605));

      // output backpressure, then release and flush the tail
      clear_stats();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      run(14);
      check("t3_held_words", 64'(words_seen), 64'(0));
      check("t3_held_valid", 64'(bus.out_valid), 64'(1));
      check("t3_held_data", 64'(bus.out_data), 64'(32'h04030201));
      check("t3_pops", 64'(pops), 64'(8));
      push_byte(8'h09); push_byte(8'h0A);
      run(4);
      check("t3_gated_pops", 64'(pops), 64'(8));
      check("t3_gated_rinc", 64'(bus.fifo_rinc), 64'(0));
      bus.out_ready = 1'b1;
      run(10);
      check("t3_release_words", 64'(words_seen), 64'(2));
      check("t3_release_pops", 64'(pops), 64'(10));
      do_flush();
      run(6);
      check("t3_tail_words", 64'(words_seen), 64'(3));
      check("t3_tail_data", 64'(last_data), 64'(32'h00000A09));
      check("t3_tail_keep", 64'(last_keep), 64'(4'h3));
      check("t3_flush_done", 64'(fd_count), 64'(1));

      // partial flush, then empty flush held two cycles
      clear_stats();
      push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
      run(6);
      check("t4_no_early_word", 64'(words_seen), 64'(0));
      do_flush();
      run(6);
      check("t4_words", 64'(words_seen), 64'(1));
      check("t4_data", 64'(last_data), 64'(32'h00CCBBAA));
      check("t4_keep", 64'(last_keep), 64'(4'h7));
      check("t4_flush_done", 64'(fd_count), 64'(1));
      clear_stats();
      bus.flush = 1'b1;
      cyc();
      cyc();
      bus.flush = 1'b0;
      run(6);
      check("t4_empty_flush_done", 64'(fd_count), 64'(1));
      check("t4_empty_flush_words", 64'(words_seen), 64'(0));

      // empty toggling every other cycle
      clear_stats();
      w = '0;
      for (int i = 0; i < PN; i++) begin
         b = 8'($urandom_range(0, 255));
         w[i*DW +: DW] = b;
         push_byte(b);
      end
      for (int k = 0; k < 16; k++) begin
         stall = (k % 2 == 0);
         cyc();
      end
      stall = 1'b0;
      run(4);
      check("t5_words", 64'(words_seen), 64'(1));
      check("t5_data", 64'(last_data), 64'(w));
      check("t5_pops", 64'(pops), 64'(4));

      // asynchronous reset mid-operation
      clear_stats();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
      run(12);
      check("t6_pre_valid", 64'(bus.out_valid), 64'(1));
      rst = 1'b1;
      #1;
      check("t6_rst_valid", 64'(bus.out_valid), 64'(0));
      check("t6_rst_data", 64'(bus.out_data), 64'(0));
      check("t6_rst_keep", 64'(bus.out_keep), 64'(0));
      check("t6_rst_rinc", 64'(bus.fifo_rinc), 64'(0));
      exp_q.delete();
      exp_keep_q.delete();
      pend_q.delete();
      hold_prev = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      bus.out_ready = 1'b1;
      w = '0;
      for (int i = 0; i < PN; i++) begin
         b = 8'($urandom_range(0, 255));
         w[i*DW +: DW] = b;
         push_byte(b);
      end
      run(10);
      check("t6_words", 64'(words_seen), 64'(1));
      check("t6_data", 64'(last_data), 64'(w));
      check("t6_keep", 64'(last_keep), 64'(4'hF));

      // random traffic, stalls and backpressure
      clear_stats();
      pushed = 0;
      for (int k = 0; k < 400 && pushed < 40; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            push_byte(8'($urandom_range(0, 255)));
            pushed++;
         end
         stall = ($urandom_range(0, 3) == 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end
      stall = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) cyc();
      check("rand_pushed", 64'(pushed), 64'(40));
      check("rand_drained", 64'(exp_q.size()), 64'(0));
      check("rand_words", 64'(words_seen), 64'(10));
      push_byte(8'($urandom_range(0, 255)));
      push_byte(8'($urandom_range(0, 255)));
      run(6);
      do_flush();
      run(8);
      check("rand_tail_drained", 64'(exp_q.size()), 64'(0));
      check("rand_tail_keep", 64'(last_keep), 64'(4'h3));
      check("rand_flush_done", 64'(fd_count), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
